// File: rtl/mem_map_pkg.sv
// Address map, register offsets and STATUS layout for the data-side memory responder.
// Shared by the responder top and anything that needs to talk to its MMIO window.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_1000;

  localparam logic [31:0] OFF_GPIO   = 32'h00;
  localparam logic [31:0] OFF_CNT    = 32'h04;
  localparam logic [31:0] OFF_CMP    = 32'h08;
  localparam logic [31:0] OFF_STATUS = 32'h0C;
  localparam logic [31:0] OFF_TXDATA = 32'h10;

  localparam int ST_MATCH     = 0;
  localparam int ST_IE        = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_FULL      = 3;
  localparam int ST_EMPTY     = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_GPIO,
    SEL_CNT,
    SEL_CMP,
    SEL_STATUS,
    SEL_TXDATA
  } mmio_sel_e;

  // Word-granular decode: the two byte-offset bits never select a register.
  function automatic mmio_sel_e mmio_decode(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] off;
    off = (addr & ~32'h3) - (base & ~32'h3);
    case (off)
      OFF_GPIO:   return SEL_GPIO;
      OFF_CNT:    return SEL_CNT;
      OFF_CMP:    return SEL_CMP;
      OFF_STATUS: return SEL_STATUS;
      OFF_TXDATA: return SEL_TXDATA;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data bus plus the TX byte stream, seen from the responder (slave) and SoC (master) sides.
interface data_mem_responder_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  MemWrite, ALUResult, WriteData, tx_ready,
    output ReadData, tx_data, tx_valid
  );

  modport master (
    output MemWrite, ALUResult, WriteData, tx_ready,
    input  ReadData, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_responder_tx_fifo.sv
// Power-of-two byte FIFO with registered storage; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle, otherwise it is dropped and flagged.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     ovf_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign ovf_o   = push_i && !do_push;
  assign valid_o = !empty_o;
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder for the single-cycle core: word RAM, GPIO, cycle timer with
// compare interrupt and a TX byte FIFO, all with zero-latency combinational reads.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 256,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [7:0]           gpio_out,
  output logic                 irq
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [RAM_WORDS];
  logic              in_ram;
  logic [RAM_AW-1:0] ram_idx;
  mmio_sel_e         sel;

  logic [7:0]  gpio_q, gpio_d;
  logic [31:0] cnt_q, cnt_d, cmp_q, cmp_d;
  logic        match_q, match_d, ie_q, ie_d, ovf_q, ovf_d;
  logic        fifo_push, fifo_full, fifo_empty, fifo_ovf;
  logic [FCW-1:0] fifo_count;
  logic [31:0] status;

  assign in_ram  = {2'b00, bus.ALUResult[31:2]} < 32'(RAM_WORDS);
  assign ram_idx = bus.ALUResult[RAM_AW+1:2];
  assign sel     = mmio_decode(bus.ALUResult, MMIO_BASE);

  assign fifo_push = bus.MemWrite && !in_ram && (sel == SEL_TXDATA);
  assign gpio_out  = gpio_q;
  assign irq       = match_q & ie_q;

  always_ff @(posedge clk) begin
    if (bus.MemWrite && in_ram) ram_q[ram_idx] <= bus.WriteData;
  end

  always_comb begin
    gpio_d  = gpio_q;
    cnt_d   = cnt_q + 32'd1;
    cmp_d   = cmp_q;
    ie_d    = ie_q;
    match_d = match_q;
    ovf_d   = ovf_q;
    if (bus.MemWrite && !in_ram) begin
      case (sel)
        SEL_GPIO:   gpio_d = bus.WriteData[7:0];
        SEL_CNT:    cnt_d  = bus.WriteData;
        SEL_CMP:    cmp_d  = bus.WriteData;
        SEL_STATUS: begin
          ie_d = bus.WriteData[ST_IE];
          if (bus.WriteData[ST_MATCH]) match_d = 1'b0;
          if (bus.WriteData[ST_OVF])   ovf_d   = 1'b0;
        end
        default: ;
      endcase
    end
    // Hardware sets land after the W1C so a same-cycle event is never lost.
    if (cnt_q == cmp_q) match_d = 1'b1;
    if (fifo_ovf)       ovf_d   = 1'b1;
  end

  always_comb begin
    status                      = '0;
    status[ST_MATCH]            = match_q;
    status[ST_IE]               = ie_q;
    status[ST_OVF]              = ovf_q;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_COUNT_LSB +: 4]   = 4'(fifo_count);
  end

  always_comb begin
    bus.ReadData = '0;
    if (in_ram) begin
      bus.ReadData = ram_q[ram_idx];
    end else begin
      case (sel)
        SEL_GPIO:   bus.ReadData = {24'd0, gpio_q};
        SEL_CNT:    bus.ReadData = cnt_q;
        SEL_CMP:    bus.ReadData = cmp_q;
        SEL_STATUS: bus.ReadData = status;
        default:    bus.ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q  <= '0;
      cnt_q   <= '0;
      cmp_q   <= CMP_RESET;
      match_q <= 1'b0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
    end
  end

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (fifo_push),
    .data_i  (bus.WriteData[7:0]),
    .pop_i   (bus.tx_ready),
    .data_o  (bus.tx_data),
    .valid_o (bus.tx_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .ovf_o   (fifo_ovf)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized RAM and
// FIFO traffic compared against a behavioural model (arrays, a byte queue, a cycle count).
module tb_data_mem_responder;
  import mem_map_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_GPIO = BASE + OFF_GPIO;
  localparam logic [31:0] A_CNT  = BASE + OFF_CNT;
  localparam logic [31:0] A_CMP  = BASE + OFF_CMP;
  localparam logic [31:0] A_ST   = BASE + OFF_STATUS;
  localparam logic [31:0] A_TX   = BASE + OFF_TXDATA;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gpio;
  logic       irq;

  data_mem_responder_if bus_if();

  data_mem_responder #(
    .RAM_WORDS  (256),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus_if),
    .gpio_out (gpio),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] txq[$];
  bit         ovf_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.MemWrite  = 1'b1;
    bus_if.ALUResult = a;
    bus_if.WriteData = d;
    tick();
    bus_if.MemWrite  = 1'b0;
    $display("wr   addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_if.ALUResult = a;
    #1;
    d = bus_if.ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #3;
    n_cmp++; if (bus_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_txvalid got=%b exp=0", bus_if.tx_valid); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b exp=0", irq); end
    #9 rst_n = 1'b1;
    rd(A_GPIO, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL rst_gpio got=%h exp=0", r); end
    rd(A_CMP, r);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_cmp got=%h exp=ffffffff", r); end
    rd(A_ST, r);
    n_cmp++; if (r !== 32'h0000_0010) begin n_err++; $display("FAIL rst_status got=%h exp=00000010", r); end
    n_cmp++; if (bus_if.tx_data !== 8'h0) begin n_err++; $display("FAIL rst_txdata got=%h exp=0", bus_if.tx_data); end
    n_cmp++; if (gpio !== 8'h0) begin n_err++; $display("FAIL rst_gpio_out got=%h exp=0", gpio); end
    $display("test_reset done");
  endtask

  task automatic test_ram();
    logic [31:0] model [int];
    logic [31:0] r, d;
    int idx;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, r);
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_10 got=%h exp=deadbeef", r); end
    rd(32'h0000_0013, r);
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_13 got=%h exp=deadbeef", r); end
    model[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) begin
      idx = int'($urandom_range(0, 255));
      d   = $urandom;
      wr({22'd0, idx[7:0], 2'($urandom_range(0, 3))}, d);
      model[idx] = d;
      rd({22'd0, idx[7:0], 2'b00}, r);
      n_cmp++; if (r !== d) begin n_err++; $display("FAIL ram_b2b idx=%0d got=%h exp=%h", idx, r, d); end
    end
    foreach (model[k]) begin
      rd({22'd0, 8'(k), 2'($urandom_range(0, 3))}, r);
      n_cmp++; if (r !== model[k]) begin n_err++; $display("FAIL ram_rb idx=%0d got=%h exp=%h", k, r, model[k]); end
    end
    $display("test_ram done");
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    rd(32'h0000_2000, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL unm_2000 got=%h exp=0", r); end
    wr(32'h0000_2000, 32'h1234_5678);
    rd(32'h0000_2000, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL unm_wr got=%h exp=0", r); end
    rd(32'h0000_0400, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL unm_400 got=%h exp=0", r); end
    rd(BASE + 32'h14, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL unm_1014 got=%h exp=0", r); end
    rd(A_TX, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL txdata_rd got=%h exp=0", r); end
    $display("test_unmapped done");
  endtask

  task automatic test_gpio();
    logic [31:0] r, d;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      wr(A_GPIO + 32'($urandom_range(0, 3)), d);
      n_cmp++; if (gpio !== d[7:0]) begin n_err++; $display("FAIL gpio_out got=%h exp=%h", gpio, d[7:0]); end
      rd(A_GPIO, r);
      n_cmp++; if (r !== {24'd0, d[7:0]}) begin n_err++; $display("FAIL gpio_rd got=%h exp=%h", r, {24'd0, d[7:0]}); end
    end
    $display("test_gpio done");
  endtask

  task automatic test_counter();
    logic [31:0] r0, r1, v;
    int n;
    rd(A_CNT, r0);
    n = int'($urandom_range(1, 9));
    for (int i = 0; i < n; i++) tick();
    rd(A_CNT, r1);
    n_cmp++; if (r1 !== r0 + 32'(n)) begin n_err++; $display("FAIL cnt_free got=%h exp=%h", r1, r0 + 32'(n)); end
    v = $urandom;
    wr(A_CNT, v);
    rd(A_CNT, r1);
    n_cmp++; if (r1 !== v) begin n_err++; $display("FAIL cnt_load got=%h exp=%h", r1, v); end
    tick(); tick(); tick();
    rd(A_CNT, r1);
    n_cmp++; if (r1 !== v + 32'd3) begin n_err++; $display("FAIL cnt_inc got=%h exp=%h", r1, v + 32'd3); end
    wr(A_CNT, 32'hFFFF_FFFE);
    tick();
    rd(A_CNT, r1);
    n_cmp++; if (r1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL cnt_max got=%h exp=ffffffff", r1); end
    tick();
    rd(A_CNT, r1);
    n_cmp++; if (r1 !== 32'h0) begin n_err++; $display("FAIL cnt_wrap got=%h exp=0", r1); end
    rd(A_ST, r1);
    n_cmp++; if (r1[ST_MATCH] !== 1'b1) begin n_err++; $display("FAIL match_at_max got=%b exp=1", r1[ST_MATCH]); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_ie_off got=%b exp=0", irq); end
    $display("test_counter done");
  endtask

  task automatic test_timer();
    logic [31:0] r;
    int  mcnt;
    bit  hit;
    wr(A_CNT, 32'd0);
    wr(A_CMP, 32'd20);
    wr(A_ST, 32'h3);
    mcnt = 2;
    hit  = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      rd(A_CNT, r);
      n_cmp++; if (r !== 32'(mcnt)) begin n_err++; $display("FAIL tmr_cnt got=%h exp=%h", r, 32'(mcnt)); end
      if (mcnt == 20) begin
        hit = 1'b1;
      end else begin
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tmr_early_irq cnt=%0d got=%b exp=0", mcnt, irq); end
        tick();
        mcnt++;
      end
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL tmr_bound got=timeout exp=cnt20"); end
    wr(A_ST, 32'h3);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL tmr_irq_set got=%b exp=1", irq); end
    rd(A_ST, r);
    n_cmp++; if (r[ST_MATCH] !== 1'b1) begin n_err++; $display("FAIL tmr_set_wins got=%b exp=1", r[ST_MATCH]); end
    tick(); tick();
    wr(A_ST, 32'h3);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL tmr_irq_clr got=%b exp=0", irq); end
    rd(A_ST, r);
    n_cmp++; if (r[1:0] !== 2'b10) begin n_err++; $display("FAIL tmr_st_clr got=%b exp=10", r[1:0]); end
    $display("test_timer done");
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] r;
    wr(A_ST, 32'h4);
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(A_TX, 32'(8'h41 + i));
    rd(A_ST, r);
    n_cmp++; if (r[11:8] !== 4'd4) begin n_err++; $display("FAIL ovf_count got=%0d exp=4", r[11:8]); end
    n_cmp++; if (r[4:2] !== 3'b010 + 3'b001) begin n_err++; $display("FAIL ovf_flags got=%b exp=011", r[4:2]); end
    bus_if.tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'(8'h41 + k))
        begin n_err++; $display("FAIL ovf_drain k=%0d got=%b/%h exp=1/%h", k, bus_if.tx_valid, bus_if.tx_data, 8'(8'h41 + k)); end
      tick();
    end
    rd(A_ST, r);
    n_cmp++; if (bus_if.tx_valid !== 1'b0 || r[ST_EMPTY] !== 1'b1)
      begin n_err++; $display("FAIL ovf_empty got=%b/%b exp=0/1", bus_if.tx_valid, r[ST_EMPTY]); end
    bus_if.tx_ready = 1'b0;
    $display("test_fifo_overflow done");
  endtask

  task automatic test_fifo_full_push();
    logic [31:0] r;
    logic [7:0]  exp_q[$];
    wr(A_ST, 32'h4);
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr(A_TX, 32'(8'h61 + i));
      exp_q.push_back(8'(8'h61 + i));
    end
    bus_if.tx_ready = 1'b1;
    wr(A_TX, 32'h55);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    rd(A_ST, r);
    n_cmp++; if (r[11:8] !== 4'd4) begin n_err++; $display("FAIL fp_count got=%0d exp=4", r[11:8]); end
    n_cmp++; if (r[ST_OVF] !== 1'b0) begin n_err++; $display("FAIL fp_ovf got=%b exp=0", r[ST_OVF]); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus_if.tx_data !== exp_q[k]) begin n_err++; $display("FAIL fp_order k=%0d got=%h exp=%h", k, bus_if.tx_data, exp_q[k]); end
      tick();
    end
    n_cmp++; if (bus_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL fp_empty got=%b exp=0", bus_if.tx_valid); end
    bus_if.tx_ready = 1'b0;
    $display("test_fifo_full_push done");
  endtask

  task automatic test_fifo_random();
    logic [31:0] r;
    logic [7:0]  b, exp_d;
    bit push, rdy, pop, full, exp_v;
    wr(A_ST, 32'h4);
    txq.delete();
    ovf_m = 1'b0;
    for (int c = 0; c < 200; c++) begin
      push = ($urandom_range(0, 9) < 6);
      rdy  = (c >= 190) ? 1'b1 : ($urandom_range(0, 9) < 4);
      if (c >= 190) push = 1'b0;
      b = 8'($urandom);
      bus_if.tx_ready  = rdy;
      bus_if.MemWrite  = push;
      bus_if.WriteData = {24'd0, b};
      bus_if.ALUResult = push ? A_TX : A_ST;
      #1;
      exp_v = (txq.size() > 0);
      exp_d = exp_v ? txq[0] : 8'h00;
      n_cmp++; if (bus_if.tx_valid !== exp_v || bus_if.tx_data !== exp_d)
        begin n_err++; $display("FAIL rnd_head c=%0d got=%b/%h exp=%b/%h", c, bus_if.tx_valid, bus_if.tx_data, exp_v, exp_d); end
      if (!push) begin
        r = bus_if.ReadData;
        n_cmp++; if (r[11:8] !== 4'(txq.size()) || r[ST_OVF] !== ovf_m || r[ST_FULL] !== (txq.size() == DEPTH) || r[ST_EMPTY] !== (txq.size() == 0))
          begin n_err++; $display("FAIL rnd_status c=%0d got=%h exp_count=%0d exp_ovf=%b", c, r, txq.size(), ovf_m); end
      end
      pop  = exp_v && rdy;
      full = (txq.size() == DEPTH);
      if (pop) void'(txq.pop_front());
      if (push) begin
        if (!full || pop) txq.push_back(b);
        else ovf_m = 1'b1;
      end
      tick();
    end
    bus_if.MemWrite = 1'b0;
    bus_if.tx_ready = 1'b0;
    $display("test_fifo_random done queued=%0d ovf=%b", txq.size(), ovf_m);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] r, d;
    d = $urandom;
    wr(32'h0000_0040, d);
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TX, $urandom);
    wr(A_CNT, 32'd1000);
    wr(A_GPIO, 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h0)
      begin n_err++; $display("FAIL mid_txvalid got=%b/%h exp=0/00", bus_if.tx_valid, bus_if.tx_data); end
    rd(A_CNT, r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL mid_cnt got=%h exp=0", r); end
    rd(A_ST, r);
    n_cmp++; if (r !== 32'h0000_0010) begin n_err++; $display("FAIL mid_status got=%h exp=00000010", r); end
    n_cmp++; if (gpio !== 8'h0) begin n_err++; $display("FAIL mid_gpio got=%h exp=0", gpio); end
    rst_n = 1'b1;
    tick();
    rd(32'h0000_0040, r);
    n_cmp++; if (r !== d) begin n_err++; $display("FAIL mid_ram got=%h exp=%h", r, d); end
    n_cmp++; if (bus_if.tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_post got=%b exp=0", bus_if.tx_valid); end
    $display("test_reset_midflight done");
  endtask

  initial begin
    bus_if.MemWrite  = 1'b0;
    bus_if.ALUResult = '0;
    bus_if.WriteData = '0;
    bus_if.tx_ready  = 1'b0;
    test_reset();
    test_ram();
    test_unmapped();
    test_gpio();
    test_counter();
    test_timer();
    test_fifo_overflow();
    test_fifo_full_push();
    test_fifo_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
